// File: rtl/red_light_capture.sv
// Red-light violation capture: debounces camera&red, fires a one-cycle shutter,
// runs a capture request/acknowledge handshake with timeout, then holds off and re-arms.
module red_light_capture #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int ACK_TIMEOUT     = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             camera,
    input  logic             red,
    input  logic             cap_ack,
    input  logic             clr_cnt,
    output logic             shutter,
    output logic             cap_req,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        QUAL,
        FIRE,
        WAIT_ACK,
        HOLDOFF,
        REARM
    } state_t;

    localparam logic [7:0]       DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);
    localparam logic [7:0]       TOUT      = 8'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t     state;
    logic [7:0] qcnt;
    logic [7:0] tcnt;
    logic [7:0] hcnt;
    logic       trig;
    logic       fire_next;
    logic       timeout_now;

    assign trig = camera & red;

    // fire_next marks the edge that enters FIRE; the counter block needs it so the
    // increment lands together with the shutter pulse.
    assign fire_next = trig &&
                       (((state == IDLE) && (DEBOUNCE_CYCLES == 1)) ||
                        ((state == QUAL) && (qcnt == DEB_LAST)));
    assign timeout_now = (state == WAIT_ACK) && !cap_ack && (tcnt == TOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            qcnt    <= '0;
            tcnt    <= '0;
            hcnt    <= '0;
            shutter <= 1'b0;
            cap_req <= 1'b0;
            busy    <= 1'b0;
        end else begin
            shutter <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        busy <= 1'b1;
                        if (fire_next) begin
                            state   <= FIRE;
                            shutter <= 1'b1;
                            cap_req <= 1'b1;
                            tcnt    <= 8'd1;
                        end else begin
                            state <= QUAL;
                            qcnt  <= 8'd1;
                        end
                    end
                end
                QUAL: begin
                    if (!trig) begin
                        state <= IDLE;
                        qcnt  <= '0;
                        busy  <= 1'b0;
                    end else if (fire_next) begin
                        state   <= FIRE;
                        qcnt    <= '0;
                        shutter <= 1'b1;
                        cap_req <= 1'b1;
                        tcnt    <= 8'd1;
                    end else begin
                        qcnt <= qcnt + 8'd1;
                    end
                end
                FIRE: begin
                    if (cap_ack) begin
                        state   <= HOLDOFF;
                        cap_req <= 1'b0;
                        tcnt    <= '0;
                        hcnt    <= '0;
                    end else begin
                        state <= WAIT_ACK;
                        tcnt  <= tcnt + 8'd1;
                    end
                end
                // An ack in the same cycle as the timeout wins, so no error is raised.
                WAIT_ACK: begin
                    if (cap_ack || (tcnt == TOUT)) begin
                        state   <= HOLDOFF;
                        cap_req <= 1'b0;
                        tcnt    <= '0;
                        hcnt    <= '0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                HOLDOFF: begin
                    if (hcnt == HOLD_LAST) begin
                        state <= REARM;
                        hcnt  <= '0;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                REARM: begin
                    if (!trig) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cap_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // A clear that meets a violation keeps that violation, and a timeout that
    // meets a clear still leaves the error flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (clr_cnt) begin
                viol_cnt <= (fire_next || (state == FIRE)) ? CNT_ONE : '0;
            end else if (fire_next && (viol_cnt != CNT_MAX)) begin
                viol_cnt <= viol_cnt + CNT_ONE;
            end
            if (clr_cnt) begin
                timeout_err <= timeout_now;
            end else if (timeout_now) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_red_light_capture.sv
// Scoreboard bench for red_light_capture: a timeline model derived from the stimulus
// arrays predicts every capture; a monitor pops and compares as the DUTs present outputs.
module tb_red_light_capture;

    localparam int DEB  = 3;
    localparam int HOLD = 8;
    localparam int TOUT = 16;
    localparam int MAXL = 512;
    localparam int TAIL = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       camera = 1'b0;
    logic       red = 1'b0;
    logic       cap_ack = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       shutter_a, cap_req_a, busy_a, terr_a;
    logic [7:0] cnt_a;
    logic       shutter_b, cap_req_b, busy_b, terr_b;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    red_light_capture #(.DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD),
                        .ACK_TIMEOUT(TOUT), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .camera(camera), .red(red), .cap_ack(cap_ack),
        .clr_cnt(clr_cnt), .shutter(shutter_a), .cap_req(cap_req_a),
        .viol_cnt(cnt_a), .busy(busy_a), .timeout_err(terr_a));

    red_light_capture #(.DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD),
                        .ACK_TIMEOUT(TOUT), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .camera(camera), .red(red), .cap_ack(cap_ack),
        .clr_cnt(clr_cnt), .shutter(shutter_b), .cap_req(cap_req_b),
        .viol_cnt(cnt_b), .busy(busy_b), .timeout_err(terr_b));

    typedef struct { int cyc; int ca; int cb; } shot_t;
    typedef struct { int len; int err; } req_t;

    shot_t shot_q[$];
    req_t  req_q[$];
    bit    s_cam[MAXL];
    bit    s_red[MAXL];
    bit    s_ack[MAXL];
    bit    s_clr[MAXL];
    bit    exp_busy[MAXL];
    int    slen;
    int    end_ca, end_cb, end_err;
    int    cur_cyc = 0;
    bit    mon_en = 1'b0;
    int    tests = 0;
    int    fails = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cur_cyc);
        end
    endtask

    function automatic bit trigAt(input int k);
        return s_cam[k] & s_red[k];
    endfunction

    task automatic clearStim(input int len);
        slen = len;
        for (int k = 0; k < MAXL; k++) begin
            s_cam[k] = 0; s_red[k] = 0; s_ack[k] = 0; s_clr[k] = 0; exp_busy[k] = 0;
        end
    endtask

    task automatic setTrig(input int from, input int to);
        for (int k = from; k <= to; k++) begin
            s_cam[k] = 1; s_red[k] = 1;
        end
    endtask

    // Timeline model: each capture is located by scanning the stimulus for the first
    // full debounce window after re-arm, then the ack window, holdoff and trig release.
    task automatic buildModel();
        int fq[$]; int hq[$]; int lq[$];
        bit fire_at[MAXL];
        bit tout_edge[MAXL];
        int ca_arr[MAXL]; int cb_arr[MAXL]; int err_arr[MAXL];
        int armed = 0;
        int f, c, h, r, len, last;
        bit ok;
        for (int k = 0; k < MAXL; k++) begin
            fire_at[k] = 0; tout_edge[k] = 0;
        end
        forever begin
            f = -1;
            for (int n = armed; n + DEB <= slen; n++) begin
                ok = 1;
                for (int j = 0; j < DEB; j++) if (!trigAt(n + j)) ok = 0;
                if (ok) begin f = n + DEB; break; end
            end
            if (f >= slen) f = -1;
            last = (f < 0) ? slen : f;
            for (int k = armed + 1; k < last; k++) exp_busy[k] = trigAt(k - 1);
            if (f < 0) break;
            c = -1;
            for (int k = f; k < f + TOUT; k++) if (s_ack[k]) begin c = k; break; end
            if (c >= 0) begin h = c + 1; len = c - f + 1; end
            else begin h = f + TOUT; len = TOUT; tout_edge[h - 1] = 1; end
            r = h + HOLD;
            while (r < slen && trigAt(r)) r++;
            for (int k = f; k <= r && k < slen; k++) exp_busy[k] = 1;
            fire_at[f] = 1;
            fq.push_back(f); hq.push_back(h); lq.push_back(len);
            armed = r + 1;
        end
        ca_arr[0] = 0; cb_arr[0] = 0; err_arr[0] = 0;
        for (int k = 0; k + 1 < slen; k++) begin
            if (s_clr[k]) begin
                ca_arr[k + 1] = (fire_at[k] || fire_at[k + 1]) ? 1 : 0;
                cb_arr[k + 1] = ca_arr[k + 1];
            end else begin
                ca_arr[k + 1] = (fire_at[k + 1] && ca_arr[k] < 255) ? ca_arr[k] + 1 : ca_arr[k];
                cb_arr[k + 1] = (fire_at[k + 1] && cb_arr[k] < 3) ? cb_arr[k] + 1 : cb_arr[k];
            end
            err_arr[k + 1] = s_clr[k] ? int'(tout_edge[k]) : (err_arr[k] | int'(tout_edge[k]));
        end
        foreach (fq[i]) begin
            shot_q.push_back('{cyc: fq[i], ca: ca_arr[fq[i]], cb: cb_arr[fq[i]]});
            req_q.push_back('{len: lq[i], err: err_arr[hq[i]]});
        end
        end_ca = ca_arr[slen - 1]; end_cb = cb_arr[slen - 1]; end_err = err_arr[slen - 1];
    endtask

    task automatic applyStimulus(input string tag);
        buildModel();
        mon_en = 0;
        camera = 0; red = 0; cap_ack = 0; clr_cnt = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < slen; i++) begin
            @(posedge clk);
            #1;
            cur_cyc = i;
            mon_en  = 1;
            camera  = s_cam[i];
            red     = s_red[i];
            cap_ack = s_ack[i];
            clr_cnt = s_clr[i];
        end
        @(negedge clk);
        checkOutput({tag, "_end_viol_cnt"}, int'(cnt_a), end_ca);
        checkOutput({tag, "_end_viol_cnt_sat"}, int'(cnt_b), end_cb);
        checkOutput({tag, "_end_timeout_err"}, int'(terr_a), end_err);
        mon_en = 0;
        @(posedge clk);
        checkOutput({tag, "_missing_shutters"}, shot_q.size(), 0);
        checkOutput({tag, "_missing_req_drops"}, req_q.size(), 0);
        shot_q.delete();
        req_q.delete();
    endtask

    task automatic genRandom(input int len);
        int k = 0;
        int seg;
        bit v;
        clearStim(len);
        while (k < len - TAIL) begin
            seg = $urandom_range(1, 8);
            v   = 1'($urandom_range(0, 1));
            for (int j = 0; j < seg && k < len - TAIL; j++) begin
                if (v) begin
                    s_cam[k] = 1; s_red[k] = 1;
                end else begin
                    case ($urandom_range(0, 2))
                        0: s_cam[k] = 1;
                        1: s_red[k] = 1;
                        default: ;
                    endcase
                end
                k++;
            end
        end
        for (int i = 0; i < len; i++) begin
            s_ack[i] = ($urandom_range(0, 4) == 0);
            s_clr[i] = ($urandom_range(0, 29) == 0);
        end
    endtask

    // Monitor: pops the capture scoreboard on every shutter and the handshake
    // scoreboard whenever cap_req falls; busy is compared every cycle.
    initial begin : monitor
        bit    prev_req = 0;
        int    run_len = 0;
        shot_t s;
        req_t  q;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checkOutput("busy", int'(busy_a), int'(exp_busy[cur_cyc]));
                checkOutput("busy_sat", int'(busy_b), int'(exp_busy[cur_cyc]));
                if (shutter_a || shutter_b) begin
                    if (shot_q.size() == 0) begin
                        checkOutput("shutter_unexpected", 1, 0);
                    end else begin
                        s = shot_q.pop_front();
                        checkOutput("shutter_cycle", cur_cyc, s.cyc);
                        checkOutput("shutter_pair", int'(shutter_a & shutter_b), 1);
                        checkOutput("viol_cnt", int'(cnt_a), s.ca);
                        checkOutput("viol_cnt_sat", int'(cnt_b), s.cb);
                    end
                end
                if (cap_req_a) begin
                    run_len++;
                end else if (prev_req) begin
                    if (req_q.size() == 0) begin
                        checkOutput("req_unexpected", run_len, 0);
                    end else begin
                        q = req_q.pop_front();
                        checkOutput("req_len", run_len, q.len);
                        checkOutput("timeout_err", int'(terr_a), q.err);
                    end
                    run_len = 0;
                end
                prev_req = cap_req_a;
            end else begin
                prev_req = 0;
                run_len  = 0;
            end
        end
    end

    task automatic resetMidHandshake();
        mon_en = 0;
        camera = 0; red = 0; cap_ack = 0; clr_cnt = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1 camera = 1; red = 1;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 camera = 0; red = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_req", int'(cap_req_a), 1);
        checkOutput("pre_reset_viol_cnt", int'(cnt_a), 1);
        #2 rst = 1;
        #1;
        checkOutput("async_req_drop", int'(cap_req_a), 0);
        checkOutput("async_busy_drop", int'(busy_a), 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checkOutput("post_reset_viol_cnt", int'(cnt_a), 0);
        checkOutput("post_reset_busy", int'(busy_a), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        // Basic qualify with ack two cycles after the shutter.
        clearStim(60);
        setTrig(10, 12);
        s_ack[15] = 1;
        applyStimulus("qualify");

        // Two short bursts separated by a one-cycle gap never qualify.
        clearStim(50);
        setTrig(5, 6);
        setTrig(8, 9);
        applyStimulus("glitch");

        // No ack: request times out, then a clear wipes count and error.
        clearStim(70);
        setTrig(10, 12);
        s_clr[55] = 1;
        applyStimulus("timeout");

        // Continuous trig yields one capture; a second needs a release.
        clearStim(140);
        setTrig(5, 64);
        setTrig(67, 69);
        applyStimulus("rearm");

        // Five violations saturate the 2-bit counter; a clear in FIRE keeps the sixth.
        clearStim(170);
        for (int p = 5; p <= 105; p += 20) begin
            setTrig(p, p + 2);
            s_ack[p + 3] = 1;
        end
        s_clr[108] = 1;
        applyStimulus("saturate");

        for (int i = 0; i < 8; i++) begin
            genRandom(300);
            applyStimulus("random");
        end

        resetMidHandshake();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
